serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 102 ++++++++++
 tb/tb_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..w without wrapping.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (a - b) mod 2^WIDTH one bit per clock,
// LSB first, reporting the final borrow.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             brw;
  logic             d_bit;
  logic             bout_bit;

  full_subtractor u_fs (
    .a   (sa[0]),
    .b   (sb[0]),
    .bin (brw),
    .d   (d_bit),
    .bout(bout_bit)
  );

  // Control FSM, operand shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sa         <= '0;
      sb         <= '0;
      brw        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            brw   <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          diff <= {d_bit, diff[WIDTH-1:1]};
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          brw  <= bout_bit;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            borrow_out <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit sa[0]/sb[0] are the operand MSBs and d_bit is
            // the result MSB.
            ovf        <= (sa[0] ^ sb[0]) & (sa[0] ^ d_bit);
`endif
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8). Optional ovf checks
// follow SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the operands.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    return W'((32'(x) - 32'(y)) & ((32'd1 << W) - 1));
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return (32'(x) < 32'(y));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy;
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  task automatic wait_idle(input string tag);
    int g = 0;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // One full transaction: accept, latency, results, post-done behaviour.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    int n;
    logic [W-1:0] held;
    wait_idle(tag);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(negedge clk);                 // accept edge has passed
    start = 1'b0;
    a = W'($urandom);               // post-accept operand changes must be ignored
    b = W'($urandom);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    // done first visible after the WIDTH-th edge following accept, i.e. it is
    // sampled high by edge WIDTH+1.
    check({tag, "_latency"}, 32'(n), 32'(W));
    check({tag, "_diff"}, 32'(diff), 32'(ref_diff(ta, tb_v)));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(ref_borrow(ta, tb_v)));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(ta, tb_v)));
`endif
    held = diff;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_diff_hold"}, 32'(diff), 32'(held));
  endtask

  initial begin
    int n_done;
    int n_cyc;
    int last_done;
    logic [W-1:0] ga;
    logic [W-1:0] gb;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op("d05_03", 8'h05, 8'h03);
    run_op("d03_05", 8'h03, 8'h05);
    run_op("d00_00", 8'h00, 8'h00);
    run_op("dFF_00", 8'hFF, 8'h00);
    run_op("d00_FF", 8'h00, 8'hFF);
    run_op("d80_01", 8'h80, 8'h01);
    run_op("d7F_01", 8'h7F, 8'h01);
    run_op("d7F_FF", 8'h7F, 8'hFF);

    // Random cases
    for (int i = 0; i < 20; i++) begin
      run_op("rnd", W'($urandom), W'($urandom));
    end

    // Second start during RUN is ignored
    wait_idle("ign");
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    ga = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        n_done++;
        ga = diff;
      end
      @(negedge clk);
    end
    check("ign_done_count", 32'(n_done), 32'd1);
    check("ign_diff", 32'(ga), 32'h0F);
    check("ign_busy", 32'(busy), 32'd0);

    // Reset in the third RUN cycle aborts the operation
    wait_idle("abort");
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_stay_idle", 32'(busy), 32'd0);
    run_op("after_abort", 8'h0A, 8'h04);

    // start held high: back-to-back operations
    wait_idle("b2b");
    ga = W'($urandom);
    gb = W'($urandom);
    qa.push_back(ga);
    qb.push_back(gb);
    a = ga;
    b = gb;
    start = 1'b1;
    n_done = 0;
    n_cyc = 0;
    last_done = -1;
    while (n_done < 3 && n_cyc < 60) begin
      @(negedge clk);
      n_cyc++;
      if (done) begin
        n_done++;
        ga = qa.pop_front();
        gb = qb.pop_front();
        check("b2b_diff", 32'(diff), 32'(ref_diff(ga, gb)));
        check("b2b_borrow", 32'(borrow_out), 32'(ref_borrow(ga, gb)));
        if (last_done >= 0) check("b2b_spacing", 32'(n_cyc - last_done), 32'(W + 2));
        last_done = n_cyc;
        if (n_done < 3) begin
          ga = W'($urandom);
          gb = W'($urandom);
          qa.push_back(ga);
          qb.push_back(gb);
          a = ga;
          b = gb;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(n_done), 32'd3);
    @(negedge clk);
    @(negedge clk);
    check("b2b_final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
